multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_if.sv | 39 +++
 rtl/multicycle_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Handshake and control bundle between the multicycle controller and its datapath/memory.
// The slave modport is the controller's view; master is the datapath/bench side.
interface multicycle_ctrl_if;
    logic        run_i;
    logic [5:0]  instr_op_i;
    logic        mem_ready_i;
    logic        zero_i;

    logic        pc_write_o;
    logic        ir_write_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic        iord_o;
    logic        reg_write_o;
    logic        alu_src_a_o;
    logic        instr_done_o;
    logic        trap_o;
    logic [1:0]  reg_dst_o;
    logic [1:0]  mem_to_reg_o;
    logic [1:0]  alu_src_b_o;
    logic [3:0]  alu_op_o;
    logic [1:0]  pc_src_o;
    logic [3:0]  state_o;
    logic [15:0] instr_cnt_o;

    modport slave (
        input  run_i, instr_op_i, mem_ready_i, zero_i,
        output pc_write_o, ir_write_o, mem_read_o, mem_write_o, iord_o, reg_write_o,
               alu_src_a_o, instr_done_o, trap_o, reg_dst_o, mem_to_reg_o, alu_src_b_o,
               alu_op_o, pc_src_o, state_o, instr_cnt_o
    );

    modport master (
        output run_i, instr_op_i, mem_ready_i, zero_i,
        input  pc_write_o, ir_write_o, mem_read_o, mem_write_o, iord_o, reg_write_o,
               alu_src_a_o, instr_done_o, trap_o, reg_dst_o, mem_to_reg_o, alu_src_b_o,
               alu_op_o, pc_src_o, state_o, instr_cnt_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM with a completed-instruction counter.
// Define MULTICYCLE_CTRL_TRAP_EN to send illegal opcodes to a sticky TRAP state instead of a NOP.
module multicycle_ctrl (
    input  logic                  clk_i,
    input  logic                  rst_i,
    multicycle_ctrl_if.slave      bus
);
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    state_e      state_q, state_d;
    logic [15:0] instr_cnt_q, instr_cnt_d;

    logic       pc_write, ir_write, mem_read, mem_write, iord, reg_write;
    logic       alu_src_a, instr_done, trap;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
    logic [3:0] alu_op;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            instr_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_cnt_d = instr_cnt_q;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        instr_done  = 1'b0;
        trap        = 1'b0;
        reg_dst     = 2'd0;
        mem_to_reg  = 2'd0;
        alu_src_b   = 2'd0;
        pc_src      = 2'd0;
        alu_op      = 4'd0;

        case (state_q)
            S_IDLE: begin
                if (bus.run_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                alu_op    = 4'd6;
                pc_write  = bus.mem_ready_i;
                ir_write  = bus.mem_ready_i;
                if (bus.mem_ready_i) state_d = S_DECODE;
            end
            S_DECODE: begin
                // ALU precomputes the branch target into ALUOut while decoding
                alu_src_b = 2'd3;
                alu_op    = 4'd6;
                case (bus.instr_op_i)
                    OP_RTYPE:              state_d = S_EXEC_R;
                    OP_ADDI, OP_ORI, OP_LUI: state_d = S_EXEC_I;
                    OP_LW, OP_SW:          state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:        state_d = S_BRANCH;
`ifdef MULTICYCLE_CTRL_TRAP_EN
                    default:               state_d = S_TRAP;
`else
                    default:               instr_done = 1'b1;
`endif
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                state_d   = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                case (bus.instr_op_i)
                    OP_ADDI: alu_op = 4'd6;
                    OP_ORI:  alu_op = 4'd7;
                    OP_LUI:  alu_op = 4'd8;
                    default: alu_op = 4'd0;
                endcase
                state_d = S_WB_ALU;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                if (bus.instr_op_i == OP_LW) begin
                    alu_op  = 4'd9;
                    state_d = S_MEM_RD;
                end else begin
                    alu_op  = 4'd10;
                    state_d = S_MEM_WR;
                end
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (bus.mem_ready_i) state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = bus.mem_ready_i;
            end
            S_WB_ALU: begin
                reg_write  = 1'b1;
                reg_dst    = (bus.instr_op_i == OP_RTYPE) ? 2'd1 : 2'd0;
                instr_done = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'd1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                pc_src     = 2'd1;
                alu_op     = (bus.instr_op_i == OP_BEQ) ? 4'd2 : 4'd3;
                pc_write   = (bus.instr_op_i == OP_BEQ) ? bus.zero_i : !bus.zero_i;
                instr_done = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_TRAP_EN
            S_TRAP: begin
                trap = 1'b1;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Completion is the only point besides IDLE where run_i is consulted
        if (instr_done) begin
            instr_cnt_d = instr_cnt_q + 16'd1;
            state_d     = bus.run_i ? S_FETCH : S_IDLE;
        end
    end

    assign bus.pc_write_o   = pc_write;
    assign bus.ir_write_o   = ir_write;
    assign bus.mem_read_o   = mem_read;
    assign bus.mem_write_o  = mem_write;
    assign bus.iord_o       = iord;
    assign bus.reg_write_o  = reg_write;
    assign bus.alu_src_a_o  = alu_src_a;
    assign bus.instr_done_o = instr_done;
    assign bus.trap_o       = trap;
    assign bus.reg_dst_o    = reg_dst;
    assign bus.mem_to_reg_o = mem_to_reg;
    assign bus.alu_src_b_o  = alu_src_b;
    assign bus.alu_op_o     = alu_op;
    assign bus.pc_src_o     = pc_src;
    assign bus.state_o      = state_q;
    assign bus.instr_cnt_o  = instr_cnt_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: one task per scenario, inline comparisons.
module tb_multicycle_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    multicycle_ctrl_if bus();

    multicycle_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.run_i = 1'b1; bus.instr_op_i = 6'd35; bus.mem_ready_i = 1'b1; bus.zero_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.state_o !== 4'd0) begin n_fail++; $display("FAIL rst_state got %0d want 0", bus.state_o); end
        n_cmp++; if (bus.instr_cnt_o !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", bus.instr_cnt_o); end
        n_cmp++; if (bus.trap_o !== 1'b0) begin n_fail++; $display("FAIL rst_trap got %0b want 0", bus.trap_o); end
        n_cmp++; if (bus.mem_read_o !== 1'b0 || bus.pc_write_o !== 1'b0) begin n_fail++; $display("FAIL rst_ctrl got rd=%0b pcw=%0b want 0 0", bus.mem_read_o, bus.pc_write_o); end
        // run held low after release: IDLE must hold
        bus.run_i = 1'b0;
        @(negedge clk); rst = 1'b0;
        tick();
        n_cmp++; if (bus.state_o !== 4'd0) begin n_fail++; $display("FAIL idle_hold got %0d want 0", bus.state_o); end
        bus.run_i = 1'b1;
        tick();
        n_cmp++; if (bus.state_o !== 4'd1) begin n_fail++; $display("FAIL idle_to_fetch got %0d want 1", bus.state_o); end
    endtask

    task automatic test_rtype();
        do_reset();
        bus.instr_op_i = 6'd0; bus.run_i = 1'b1; bus.mem_ready_i = 1'b1; bus.zero_i = 1'b0;
        tick();
        n_cmp++; if (bus.state_o !== 4'd1) begin n_fail++; $display("FAIL r_fetch_state got %0d want 1", bus.state_o); end
        n_cmp++; if ({bus.pc_write_o, bus.ir_write_o, bus.mem_read_o, bus.iord_o} !== 4'b1110) begin n_fail++; $display("FAIL r_fetch_ctrl got %b want 1110", {bus.pc_write_o, bus.ir_write_o, bus.mem_read_o, bus.iord_o}); end
        n_cmp++; if (bus.alu_src_b_o !== 2'd1 || bus.alu_op_o !== 4'd6) begin n_fail++; $display("FAIL r_fetch_alu got b=%0d op=%0d want 1 6", bus.alu_src_b_o, bus.alu_op_o); end
        tick();
        n_cmp++; if (bus.state_o !== 4'd2 || bus.alu_src_b_o !== 2'd3) begin n_fail++; $display("FAIL r_decode got st=%0d b=%0d want 2 3", bus.state_o, bus.alu_src_b_o); end
        tick();
        n_cmp++; if (bus.state_o !== 4'd3 || bus.alu_src_a_o !== 1'b1 || bus.alu_src_b_o !== 2'd0) begin n_fail++; $display("FAIL r_exec got st=%0d a=%0b b=%0d want 3 1 0", bus.state_o, bus.alu_src_a_o, bus.alu_src_b_o); end
        tick();
        n_cmp++; if (bus.state_o !== 4'd8) begin n_fail++; $display("FAIL r_wb_state got %0d want 8", bus.state_o); end
        n_cmp++; if (bus.reg_write_o !== 1'b1 || bus.reg_dst_o !== 2'd1 || bus.instr_done_o !== 1'b1) begin n_fail++; $display("FAIL r_wb_ctrl got rw=%0b dst=%0d done=%0b want 1 1 1", bus.reg_write_o, bus.reg_dst_o, bus.instr_done_o); end
        tick();
        n_cmp++; if (bus.state_o !== 4'd1 || bus.instr_cnt_o !== 16'd1) begin n_fail++; $display("FAIL r_done got st=%0d cnt=%0d want 1 1", bus.state_o, bus.instr_cnt_o); end
        n_cmp++; if (bus.instr_done_o !== 1'b0) begin n_fail++; $display("FAIL r_done_pulse got %0b want 0", bus.instr_done_o); end
    endtask

    task automatic test_itype();
        do_reset();
        bus.instr_op_i = 6'd13; bus.run_i = 1'b1; bus.mem_ready_i = 1'b1;
        repeat (3) tick();
        n_cmp++; if (bus.state_o !== 4'd4 || bus.alu_src_b_o !== 2'd2 || bus.alu_op_o !== 4'd7) begin n_fail++; $display("FAIL ori_exec got st=%0d b=%0d op=%0d want 4 2 7", bus.state_o, bus.alu_src_b_o, bus.alu_op_o); end
        tick();
        n_cmp++; if (bus.state_o !== 4'd8 || bus.reg_dst_o !== 2'd0 || bus.reg_write_o !== 1'b1) begin n_fail++; $display("FAIL ori_wb got st=%0d dst=%0d rw=%0b want 8 0 1", bus.state_o, bus.reg_dst_o, bus.reg_write_o); end
        tick();
        bus.instr_op_i = 6'd15;
        repeat (2) tick();
        n_cmp++; if (bus.state_o !== 4'd4 || bus.alu_op_o !== 4'd8) begin n_fail++; $display("FAIL lui_exec got st=%0d op=%0d want 4 8", bus.state_o, bus.alu_op_o); end
        repeat (2) tick();
        n_cmp++; if (bus.instr_cnt_o !== 16'd2 || bus.state_o !== 4'd1) begin n_fail++; $display("FAIL itype_cnt got cnt=%0d st=%0d want 2 1", bus.instr_cnt_o, bus.state_o); end
    endtask

    task automatic test_lw_wait();
        do_reset();
        bus.instr_op_i = 6'd35; bus.run_i = 1'b1; bus.mem_ready_i = 1'b1;
        repeat (3) tick();
        n_cmp++; if (bus.state_o !== 4'd5 || bus.alu_op_o !== 4'd9) begin n_fail++; $display("FAIL lw_addr got st=%0d op=%0d want 5 9", bus.state_o, bus.alu_op_o); end
        bus.mem_ready_i = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus.state_o !== 4'd6 || bus.mem_read_o !== 1'b1 || bus.iord_o !== 1'b1 || bus.instr_done_o !== 1'b0) begin n_fail++; $display("FAIL lw_wait%0d got st=%0d rd=%0b iord=%0b want 6 1 1", i, bus.state_o, bus.mem_read_o, bus.iord_o); end
            tick();
        end
        n_cmp++; if (bus.state_o !== 4'd6) begin n_fail++; $display("FAIL lw_wait_end got %0d want 6", bus.state_o); end
        bus.mem_ready_i = 1'b1;
        tick();
        n_cmp++; if (bus.state_o !== 4'd9 || bus.mem_to_reg_o !== 2'd1 || bus.reg_write_o !== 1'b1 || bus.instr_done_o !== 1'b1) begin n_fail++; $display("FAIL lw_wb got st=%0d m2r=%0d rw=%0b done=%0b want 9 1 1 1", bus.state_o, bus.mem_to_reg_o, bus.reg_write_o, bus.instr_done_o); end
        n_cmp++; if (bus.instr_cnt_o !== 16'd0) begin n_fail++; $display("FAIL lw_cnt_before got %0d want 0", bus.instr_cnt_o); end
        bus.run_i = 1'b0;
        tick();
        n_cmp++; if (bus.state_o !== 4'd0 || bus.instr_cnt_o !== 16'd1) begin n_fail++; $display("FAIL lw_done got st=%0d cnt=%0d want 0 1", bus.state_o, bus.instr_cnt_o); end
    endtask

    task automatic test_branch();
        do_reset();
        bus.instr_op_i = 6'd4; bus.run_i = 1'b1; bus.mem_ready_i = 1'b1; bus.zero_i = 1'b1;
        repeat (3) tick();
        n_cmp++; if (bus.state_o !== 4'd10 || bus.pc_write_o !== 1'b1 || bus.pc_src_o !== 2'd1 || bus.alu_op_o !== 4'd2) begin n_fail++; $display("FAIL beq got st=%0d pcw=%0b src=%0d op=%0d want 10 1 1 2", bus.state_o, bus.pc_write_o, bus.pc_src_o, bus.alu_op_o); end
        n_cmp++; if (bus.instr_done_o !== 1'b1) begin n_fail++; $display("FAIL beq_done got %0b want 1", bus.instr_done_o); end
        tick();
        bus.instr_op_i = 6'd5;
        repeat (2) tick();
        n_cmp++; if (bus.state_o !== 4'd10 || bus.pc_write_o !== 1'b0 || bus.alu_op_o !== 4'd3) begin n_fail++; $display("FAIL bne_z1 got st=%0d pcw=%0b op=%0d want 10 0 3", bus.state_o, bus.pc_write_o, bus.alu_op_o); end
        bus.zero_i = 1'b0;
        #1;
        n_cmp++; if (bus.pc_write_o !== 1'b1) begin n_fail++; $display("FAIL bne_z0 got %0b want 1", bus.pc_write_o); end
        tick();
        n_cmp++; if (bus.state_o !== 4'd1 || bus.instr_cnt_o !== 16'd2) begin n_fail++; $display("FAIL br_cnt got st=%0d cnt=%0d want 1 2", bus.state_o, bus.instr_cnt_o); end
    endtask

    task automatic test_rst_mid_memwr();
        do_reset();
        bus.instr_op_i = 6'd43; bus.run_i = 1'b1; bus.mem_ready_i = 1'b1;
        repeat (3) tick();
        n_cmp++; if (bus.state_o !== 4'd5 || bus.alu_op_o !== 4'd10) begin n_fail++; $display("FAIL sw_addr got st=%0d op=%0d want 5 10", bus.state_o, bus.alu_op_o); end
        tick();
        n_cmp++; if (bus.state_o !== 4'd7 || bus.mem_write_o !== 1'b1 || bus.instr_done_o !== 1'b1) begin n_fail++; $display("FAIL sw_fast got st=%0d wr=%0b done=%0b want 7 1 1", bus.state_o, bus.mem_write_o, bus.instr_done_o); end
        repeat (3) tick();
        bus.mem_ready_i = 1'b0;
        tick();
        n_cmp++; if (bus.state_o !== 4'd7 || bus.mem_write_o !== 1'b1 || bus.iord_o !== 1'b1 || bus.instr_cnt_o !== 16'd1) begin n_fail++; $display("FAIL sw_wait got st=%0d wr=%0b iord=%0b cnt=%0d want 7 1 1 1", bus.state_o, bus.mem_write_o, bus.iord_o, bus.instr_cnt_o); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.mem_write_o !== 1'b0 || bus.iord_o !== 1'b0 || bus.state_o !== 4'd0 || bus.instr_cnt_o !== 16'd0) begin n_fail++; $display("FAIL async_rst got wr=%0b iord=%0b st=%0d cnt=%0d want 0 0 0 0", bus.mem_write_o, bus.iord_o, bus.state_o, bus.instr_cnt_o); end
        #1;
        rst = 1'b0;
        bus.mem_ready_i = 1'b1;
    endtask

    task automatic test_illegal();
        do_reset();
        bus.instr_op_i = 6'h3F; bus.run_i = 1'b1; bus.mem_ready_i = 1'b1;
        repeat (2) tick();
`ifdef MULTICYCLE_CTRL_TRAP_EN
        n_cmp++; if (bus.state_o !== 4'd2 || bus.instr_done_o !== 1'b0) begin n_fail++; $display("FAIL ill_decode got st=%0d done=%0b want 2 0", bus.state_o, bus.instr_done_o); end
        tick();
        n_cmp++; if (bus.state_o !== 4'd11 || bus.trap_o !== 1'b1 || bus.mem_read_o !== 1'b0 || bus.pc_write_o !== 1'b0) begin n_fail++; $display("FAIL trap got st=%0d trap=%0b rd=%0b pcw=%0b want 11 1 0 0", bus.state_o, bus.trap_o, bus.mem_read_o, bus.pc_write_o); end
        repeat (3) tick();
        n_cmp++; if (bus.state_o !== 4'd11 || bus.trap_o !== 1'b1 || bus.instr_cnt_o !== 16'd0) begin n_fail++; $display("FAIL trap_hold got st=%0d trap=%0b cnt=%0d want 11 1 0", bus.state_o, bus.trap_o, bus.instr_cnt_o); end
        do_reset();
        #1;
        n_cmp++; if (bus.trap_o !== 1'b0 || bus.state_o !== 4'd0) begin n_fail++; $display("FAIL trap_clear got trap=%0b st=%0d want 0 0", bus.trap_o, bus.state_o); end
`else
        n_cmp++; if (bus.state_o !== 4'd2 || bus.instr_done_o !== 1'b1 || bus.trap_o !== 1'b0) begin n_fail++; $display("FAIL nop_decode got st=%0d done=%0b trap=%0b want 2 1 0", bus.state_o, bus.instr_done_o, bus.trap_o); end
        tick();
        n_cmp++; if (bus.state_o !== 4'd1 || bus.instr_cnt_o !== 16'd1) begin n_fail++; $display("FAIL nop_done got st=%0d cnt=%0d want 1 1", bus.state_o, bus.instr_cnt_o); end
`endif
    endtask

    task automatic test_wrap();
        do_reset();
        bus.run_i = 1'b0; bus.instr_op_i = 6'd43; bus.mem_ready_i = 1'b1;
        @(negedge clk);
        force dut.instr_cnt_q = 16'hFFFF;
        tick();
        release dut.instr_cnt_q;
        tick();
        n_cmp++; if (bus.instr_cnt_o !== 16'hFFFF || bus.state_o !== 4'd0) begin n_fail++; $display("FAIL wrap_preload got cnt=%h st=%0d want ffff 0", bus.instr_cnt_o, bus.state_o); end
        bus.run_i = 1'b1;
        repeat (4) tick();
        n_cmp++; if (bus.state_o !== 4'd7 || bus.instr_done_o !== 1'b1) begin n_fail++; $display("FAIL wrap_sw got st=%0d done=%0b want 7 1", bus.state_o, bus.instr_done_o); end
        bus.run_i = 1'b0;
        tick();
        n_cmp++; if (bus.instr_cnt_o !== 16'h0000 || bus.state_o !== 4'd0) begin n_fail++; $display("FAIL wrap_cnt got cnt=%h st=%0d want 0000 0", bus.instr_cnt_o, bus.state_o); end
        tick();
        n_cmp++; if (bus.state_o !== 4'd0 || bus.mem_read_o !== 1'b0) begin n_fail++; $display("FAIL wrap_idle got st=%0d rd=%0b want 0 0", bus.state_o, bus.mem_read_o); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_rtype();
        test_itype();
        test_lw_wait();
        test_branch();
        test_rst_mid_memwr();
        test_illegal();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
